// File: rtl/sipo_collector.sv
// Serial-in/parallel-out collector: assembles WIDTH serial bits into a word and
// holds it in a separate output register, so collection continues while a word waits.
module sipo_collector #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    input  logic                     s_valid,
    output logic [WIDTH-1:0]         Data_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CntW-1:0]  cnt_q,   cnt_d;
    logic             ovr_q,   ovr_d;
    logic             complete;
    logic             load;

    // shift_d already contains the completing bit, so it is what loads into data_q
    always_comb begin
        shift_d = shift_q;
        if (s_valid) begin
            if (LSB_FIRST) begin
                shift_d = {s_in, shift_q[WIDTH-1:1]};
            end else begin
                shift_d = {shift_q[WIDTH-2:0], s_in};
            end
        end
    end

    assign complete = s_valid && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (complete) begin
            cnt_d = '0;
        end else if (s_valid) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovr_d   = ovr_q;
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (complete) begin
                    // back-to-back handoff when accepted on the same edge; otherwise drop
                    if (word_ready) begin
                        load = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (word_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    assign data_d = load ? shift_d : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            shift_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Data_out   = data_q;
    assign word_valid = (state_q == StFull);
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector: LSB-first and MSB-first instances on shared stimulus,
// checked every cycle against a bit-queue model plus hand-computed literals.
module tb_sipo_collector;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         s_in;
    logic         s_valid;
    logic         word_ready;
    logic [W-1:0] dout_l, dout_m;
    logic         wv_l, wv_m;
    logic [1:0]   cnt_l, cnt_m;
    logic         ovr_l, ovr_m;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model state: bits of the word in progress, plus the handed-off word
    bit           q[$];
    logic         m_valid;
    logic         m_ovr;
    logic [W-1:0] m_data_l;
    logic [W-1:0] m_data_m;

    sipo_collector #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .Data_out  (dout_l),
        .word_valid(wv_l),
        .word_ready(word_ready),
        .bit_cnt   (cnt_l),
        .overrun   (ovr_l)
    );

    sipo_collector #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .s_valid   (s_valid),
        .Data_out  (dout_m),
        .word_valid(wv_m),
        .word_ready(word_ready),
        .bit_cnt   (cnt_m),
        .overrun   (ovr_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic         done;
        logic [W-1:0] wl, wm;
        done = 1'b0;
        wl   = '0;
        wm   = '0;
        if (rst) begin
            q.delete();
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
            m_data_l = '0;
            m_data_m = '0;
        end else begin
            if (s_valid) begin
                q.push_back(s_in);
                if (q.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wl[i]       = q[i];
                        wm[W-1-i]   = q[i];
                    end
                    q.delete();
                end
            end
            if (done) begin
                if (!m_valid || word_ready) begin
                    m_data_l = wl;
                    m_data_m = wm;
                    m_valid  = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && word_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp dout_l", dout_l, m_data_l);
            check("cmp dout_m", dout_m, m_data_m);
            check("cmp wv_l", wv_l, m_valid);
            check("cmp wv_m", wv_m, m_valid);
            check("cmp cnt_l", cnt_l, 32'(q.size()));
            check("cmp cnt_m", cnt_m, 32'(q.size()));
            check("cmp ovr_l", ovr_l, m_ovr);
            check("cmp ovr_m", ovr_m, m_ovr);
        end
    end

    // One clock: drive on negedge, model after posedge, return 2 time units past the edge
    task automatic step(input logic r, input logic sv, input logic si, input logic rdy);
        @(negedge clk);
        rst        = r;
        s_valid    = sv;
        s_in       = si;
        word_ready = rdy;
        @(posedge clk);
        #1;
        model_update();
        #1;
    endtask

    task automatic send_bit(input logic b, input logic rdy);
        step(1'b0, 1'b1, b, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, rdy);
    endtask

    // Sends w[0] first; LSB-first instance reassembles w exactly
    task automatic send_word(input logic [W-1:0] w, input logic rdy_rest, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], (i == W - 1) ? rdy_last : rdy_rest);
        end
    endtask

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_in       = 1'b0;
        word_ready = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset dout_l", dout_l, 4'b0000);
        check("reset dout_m", dout_m, 4'b0000);
        check("reset wv_l", wv_l, 1'b0);
        check("reset cnt_l", cnt_l, 2'd0);
        check("reset ovr_l", ovr_l, 1'b0);

        // Bits 1,0,1,1 with ready held high
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check("lsb wv before last", wv_l, 1'b0);
        send_bit(1'b1, 1'b1);
        check("lsb word", dout_l, 4'b1101);
        check("lsb wv", wv_l, 1'b1);
        check("msb word", dout_m, 4'b1011);
        idle(1'b1);
        check("wv drops", wv_l, 1'b0);
        check("dout retained", dout_l, 4'b1101);

        // Bits 1,1,0,0 with 3-cycle gaps
        send_bit(1'b1, 1'b1);
        check("gap cnt1", cnt_l, 2'd1);
        repeat (3) idle(1'b1);
        check("gap cnt held", cnt_l, 2'd1);
        send_bit(1'b1, 1'b1);
        check("gap cnt2", cnt_l, 2'd2);
        repeat (3) idle(1'b1);
        send_bit(1'b0, 1'b1);
        check("gap cnt3", cnt_l, 2'd3);
        repeat (3) idle(1'b1);
        send_bit(1'b0, 1'b1);
        check("gap cnt0", cnt_l, 2'd0);
        check("gap word", dout_l, 4'b0011);

        // Overrun: two words while never ready
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b1101, 1'b0, 1'b0);
        check("ovr first ok", ovr_l, 1'b0);
        send_word(4'b0110, 1'b0, 1'b0);
        check("ovr dout held", dout_l, 4'b1101);
        check("ovr set", ovr_l, 1'b1);
        check("ovr cnt wrap", cnt_l, 2'd0);
        check("ovr wv", wv_l, 1'b1);
        idle(1'b1);
        check("ovr wv drops", wv_l, 1'b0);
        check("ovr sticky", ovr_l, 1'b1);
        repeat (2) idle(1'b1);
        check("ovr still sticky", ovr_m, 1'b1);

        // Accept on the edge that completes the second word
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b0001, 1'b0, 1'b0);
        check("b2b first", dout_l, 4'b0001);
        send_word(4'b1000, 1'b0, 1'b1);
        check("b2b wv", wv_l, 1'b1);
        check("b2b word", dout_l, 4'b1000);
        check("b2b no ovr", ovr_l, 1'b0);

        // Reset mid-word
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b1111, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("mid rst dout", dout_l, 4'b0000);
        check("mid rst wv", wv_l, 1'b0);
        check("mid rst cnt", cnt_l, 2'd0);
        check("mid rst ovr", ovr_l, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        check("post rst word", dout_l, 4'b1010);
        check("post rst word msb", dout_m, 4'b0101);

        // Mixed deterministic traffic, checked by the per-cycle compare
        for (int i = 0; i < 160; i++) begin
            step(i == 80, (i % 3) != 0, ((i * 7) % 5) < 2, (i % 4) != 1 && (i % 11) != 3);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
